period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 133 +++++++++++++
 tb/tb_period_meter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures the spacing of rising edges on an asynchronous input in clk_in cycles,
// with a valid/ready result handshake, a timeout pulse and a sticky overrun flag.
module period_meter #(
  parameter int unsigned WIDTH          = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             enable_in,
  input  logic             sig_in,
  input  logic             ready_in,
  output logic [WIDTH-1:0] period_out,
  output logic             valid_out,
  output logic             timeout_out,
  output logic             overrun_out
);

  typedef enum logic {
    IDLE,
    MEASURING
  } state_t;

  // TIMEOUT_CYCLES must fit in WIDTH bits so the counter can reach it without wrapping.
  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;

  logic s1_q, s2_q, s3_q;
  logic sig_rise;

  // NOTE: s1/s2 form the metastability synchronizer; s3 only delays s2 for edge detection.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge value,
      // so the three stages shift by exactly one cycle each.
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sig_rise = s2_q & ~s3_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    overrun_d = overrun_q;

    // A consumed result drops unless a new one lands in the same cycle below.
    if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end

    if (!enable_in) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sig_rise) begin
            cnt_d   = ONE_W;
            state_d = MEASURING;
          end
        end
        MEASURING: begin
          if (sig_rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = ONE_W;
            if (valid_q && !ready_in) begin
              overrun_d = 1'b1;
            end
          end else if (cnt_q == TIMEOUT_W) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + ONE_W;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign period_out  = period_q;
  assign valid_out   = valid_q;
  assign timeout_out = timeout_q;
  assign overrun_out = overrun_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed scenarios plus randomized edge
// spacing, ready, enable and reset, compared every cycle against a timestamp model.
module tb_period_meter;

  localparam int W  = 16;
  localparam int TO = 50;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         enable_in;
  logic         sig_in;
  logic         ready_in;
  logic [W-1:0] period_out;
  logic         valid_out;
  logic         timeout_out;
  logic         overrun_out;

  always #5 clk_in = ~clk_in;

  period_meter #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(32'(TO))
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .enable_in  (enable_in),
    .sig_in     (sig_in),
    .ready_in   (ready_in),
    .period_out (period_out),
    .valid_out  (valid_out),
    .timeout_out(timeout_out),
    .overrun_out(overrun_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: time-stamps each detected rising edge (cycle index of its effect)
  // and derives period, timeout and handshake state from those timestamps.
  int       t_now;
  int       t_last;
  bit       armed;
  bit [2:0] samples;  // samples[0] newest synchronized sample of sig_in
  bit       started;
  int       m_period;
  bit       m_valid, m_timeout, m_overrun;
  int       n_valid_cyc, n_timeout;

  task automatic model_step();
    bit was_valid;
    bit rise;
    t_now++;
    if (rst_in) begin
      samples   = '0;
      armed     = 1'b0;
      m_period  = 0;
      m_valid   = 1'b0;
      m_timeout = 1'b0;
      m_overrun = 1'b0;
      started   = 1'b1;
      return;
    end
    was_valid = m_valid;
    rise      = samples[1] && !samples[2];
    m_timeout = 1'b0;
    if (was_valid && ready_in) m_valid = 1'b0;
    if (!enable_in) begin
      armed = 1'b0;
    end else if (rise) begin
      if (armed) begin
        if (was_valid && !ready_in) m_overrun = 1'b1;
        m_period = t_now - t_last;
        m_valid  = 1'b1;
      end
      armed  = 1'b1;
      t_last = t_now;
    end else if (armed && (t_now - t_last) == TO) begin
      armed     = 1'b0;
      m_timeout = 1'b1;
    end
    samples = {samples[1:0], sig_in};
  endtask

  task automatic compare_all();
    if (!started) return;
    check("valid", 32'(valid_out), 32'(m_valid));
    check("timeout", 32'(timeout_out), 32'(m_timeout));
    check("overrun", 32'(overrun_out), 32'(m_overrun));
    check("period", 32'(period_out), 32'(m_period));
    if (valid_out === 1'b1) n_valid_cyc++;
    if (timeout_out === 1'b1) n_timeout++;
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk_in);
      model_step();
      @(negedge clk_in);
      compare_all();
    end
  endtask

  task automatic do_reset();
    sig_in      = 1'b0;
    rst_in      = 1'b1;
    run(1);
    rst_in      = 1'b0;
    n_valid_cyc = 0;
    n_timeout   = 0;
  endtask

  task automatic edge_gap(input int gap);
    sig_in = 1'b1;
    run(2);
    sig_in = 1'b0;
    run(gap - 2);
  endtask

  initial begin
    rst_in    = 1'b1;
    enable_in = 1'b1;
    sig_in    = 1'b0;
    ready_in  = 1'b1;
    t_now     = 0;
    t_last    = 0;
    started   = 1'b0;
    @(negedge clk_in);
    do_reset();
    check("reset_period", 32'(period_out), 0);
    check("reset_valid", 32'(valid_out), 0);
    check("reset_overrun", 32'(overrun_out), 0);

    // Square wave, period 10, always ready: one-cycle pulses of 10.
    for (int i = 0; i < 6; i++) begin
      sig_in = 1'b1;
      run(5);
      sig_in = 1'b0;
      run(5);
    end
    check("sq_pulses", 32'(n_valid_cyc), 5);
    check("sq_period", 32'(period_out), 10);

    // Single edge then silence: exactly one timeout, never valid.
    do_reset();
    edge_gap(75);
    check("to_count", 32'(n_timeout), 1);
    check("to_valid_cycles", 32'(n_valid_cyc), 0);

    // Not ready, spacing 7 then 12: overwrite flags overrun.
    do_reset();
    ready_in = 1'b0;
    edge_gap(7);
    edge_gap(12);
    edge_gap(5);
    check("ovr_period", 32'(period_out), 12);
    check("ovr_valid", 32'(valid_out), 1);
    check("ovr_flag", 32'(overrun_out), 1);
    ready_in = 1'b1;
    run(1);
    ready_in = 1'b0;
    run(2);
    check("ovr_consumed", 32'(valid_out), 0);
    check("ovr_sticky", 32'(overrun_out), 1);

    // Edge coinciding with cnt == TIMEOUT completes the measurement.
    do_reset();
    edge_gap(50);
    edge_gap(5);
    check("edge_at_to_period", 32'(period_out), 50);
    check("edge_at_to_valid", 32'(valid_out), 1);
    check("edge_at_to_no_to", 32'(n_timeout), 0);

    // Reset 5 cycles into a 20-cycle period discards the partial count.
    do_reset();
    edge_gap(20);
    sig_in = 1'b1;
    run(2);
    sig_in = 1'b0;
    run(3);
    do_reset();
    check("mid_rst_period", 32'(period_out), 0);
    check("mid_rst_overrun", 32'(overrun_out), 0);
    sig_in = 1'b1;
    run(2);
    sig_in = 1'b0;
    run(18);
    check("mid_rst_arm_only", 32'(n_valid_cyc), 0);
    edge_gap(5);
    check("mid_rst_period20", 32'(period_out), 20);
    check("mid_rst_valid", 32'(valid_out), 1);

    // Enable dropped for 3 cycles mid-measurement.
    do_reset();
    ready_in = 1'b0;
    edge_gap(12);
    enable_in = 1'b0;
    run(3);
    enable_in = 1'b1;
    run(60);
    check("en_no_valid", 32'(n_valid_cyc), 0);
    check("en_no_timeout", 32'(n_timeout), 0);
    edge_gap(15);
    check("en_arm_only", 32'(valid_out), 0);
    edge_gap(5);
    check("en_period", 32'(period_out), 15);
    check("en_valid", 32'(valid_out), 1);

    // Randomized stimulus; the model is compared every cycle.
    do_reset();
    for (int e = 0; e < 200; e++) begin
      int gap;
      gap = int'($urandom_range(4, 70));
      for (int c = 0; c < gap; c++) begin
        sig_in    = (c < 2);
        ready_in  = ($urandom_range(0, 3) != 0);
        enable_in = ($urandom_range(0, 99) >= 2);
        rst_in    = ($urandom_range(0, 499) == 0);
        run(1);
      end
    end
    rst_in    = 1'b0;
    enable_in = 1'b1;
    run(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
